// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
// No logic: widths, FSM encoding, port ids and the latched access record.
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_t;

    // One requester's access as seen on its port inputs.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Lone requester wins outright; on a tie the pointer flips the choice.
    always_comb begin
        valid  = |req;
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between CPU (port 0) and host loader (port 1).
// Latency: req sampled at edge t -> gnt in cycle t+1 -> done in cycle t+2; read data visible in rdataN the cycle after done.
// Backpressure: requesters hold req/we/addr/wdata until gnt; one access in flight, back-to-back rate one per 2 cycles.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    state_t state;
    port_t  last;       // port granted most recently
    port_t  cur;        // port owning the access in flight
    logic   cur_we;
    logic   pick_vld;
    logic   pick_win;
    logic   launch;
    acc_t   acc0;
    acc_t   acc1;
    acc_t   pick_acc;

    assign acc0 = {we0, addr0, wdata0};
    assign acc1 = {we1, addr1, wdata1};

    rr_pick u_rr_pick (
        .req    ({req1, req0}),
        .last   (last),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    // Field set of whichever port the round-robin picked.
    always_comb begin
        pick_acc = acc0;
        if (pick_win) begin
            pick_acc = acc1;
        end
    end

    // A new access may start from IDLE or directly out of RESP.
    assign launch = pick_vld && ((state == ST_IDLE) || (state == ST_RESP));

    // Access sequencer: all outputs registered, pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= ST_IDLE;
            last      <= PORT_HOST;
            cur       <= PORT_CPU;
            cur_we    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;

            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    done0 <= (cur == PORT_CPU);
                    done1 <= (cur == PORT_HOST);
                end
                ST_RESP: begin
                    // Memory answers one cycle after mem_rd, i.e. during RESP.
                    if (!cur_we) begin
                        if (cur == PORT_HOST) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                    end
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Latch the winner and issue its memory command; overrides the RESP->IDLE exit.
            if (launch) begin
                state    <= ST_ACCESS;
                busy     <= 1'b1;
                cur      <= port_t'(pick_win);
                last     <= port_t'(pick_win);
                cur_we   <= pick_acc.we;
                gnt0     <= ~pick_win;
                gnt1     <= pick_win;
                mem_rd   <= ~pick_acc.we;
                mem_wr   <= pick_acc.we;
                mem_addr <= pick_acc.addr;
                if (pick_acc.we) begin
                    mem_wdata <= pick_acc.wdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and reset: clk input 1, rising-edge system clock; rst_ input 1, asynchronous active-low reset.
REQ-002 SHALL expose for each requester port N in {0,1} (0 = CPU controller, 1 = host loader): reqN input 1, access request; weN input 1, 1 = write, 0 = read; addrN input 5, word address; wdataN input 8, write data.
REQ-003 SHALL expose for each port N: gntN output 1, access accepted (one-cycle pulse); doneN output 1, access complete (one-cycle pulse); rdataN output 8, registered read data.
REQ-004 SHALL expose to the single-port memory: mem_addr output 5; mem_wdata output 8; mem_rd output 1; mem_wr output 1; mem_rdata input 8 (valid one cycle after mem_rd).
REQ-005 SHALL expose busy output 1, asserted in any state other than IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-007 IDLE: no request -> stay in IDLE; any reqN sampled high -> register the winner and its we/addr/wdata, go to ACCESS.
REQ-008 ACCESS: drive mem_addr from the latched addr; assert mem_rd for a read or mem_wr with mem_wdata for a write; pulse gnt of the winner; go to RESP.
REQ-009 RESP: pulse done of the winner; for a read, load rdata of the winner from mem_rdata on the same edge; pending request -> arbitrate and go directly to ACCESS, else go to IDLE.
REQ-010 Latency: req sampled at edge t -> gnt high in cycle t+1 -> done high in cycle t+2. Back-to-back throughput is one access per 2 cycles.
REQ-011 Arbitration SHALL be round-robin: when both requests are high, the port not granted last wins; a lone requester always wins.
REQ-012 The last-granted pointer SHALL update only when a grant is issued.
REQ-013 Requesters SHALL hold reqN, weN, addrN and wdataN stable until gntN. Once the winner is registered the access completes even if reqN drops; the arbiter never aborts an access.
REQ-014 A requester SHALL drop reqN in the cycle after gntN, or a new access is arbitrated for it in RESP.
REQ-015 rdataN SHALL hold its value until the next read completes on port N; writes and other-port activity leave it unchanged.
REQ-016 mem_rd and mem_wr SHALL be mutually exclusive and asserted only in ACCESS; gnt0/gnt1 and done0/done1 SHALL each be one-hot-or-zero.
REQ-017 Both ports addressing the same word: ordering follows grant order; the arbiter performs no merging or forwarding.
REQ-018 All outputs except rdataN SHALL be decoded from state and the latched winner only (Moore).

Reset
REQ-019 On rst_ low, asynchronously: state = IDLE, pointer = port 1 (so port 0 wins the first tie), all gnt/done/mem_rd/mem_wr/busy = 0, mem_addr = 0, mem_wdata = 0, rdata0 = rdata1 = 0.
REQ-020 Reset asserted mid-access SHALL abandon the access with no done pulse; after release the FSM restarts from IDLE.

Structure
REQ-021 A shared package mem_arb_pkg SHALL hold ADDR_W = 5, DATA_W = 8, the state enum, and a port-id typedef (PORT_CPU = 0, PORT_HOST = 1).
REQ-022 Round-robin selection SHALL be a sub-module rr_pick: inputs req[1:0] and last; outputs valid and winner; purely combinational.

Verification
REQ-023 Reset: hold rst_ low mid-ACCESS -> all outputs 0 immediately, no done; after release with no requests, busy stays 0.
REQ-024 Single read: preload mem[5] = 8'hA7; req0 = 1, we0 = 0, addr0 = 5 -> gnt0 in cycle t+1 with mem_rd = 1 and mem_addr = 5; done0 in t+2; rdata0 = 8'hA7.
REQ-025 Single write: req1 = 1, we1 = 1, addr1 = 31, wdata1 = 8'h3C -> mem_wr = 1, mem_addr = 31, mem_wdata = 8'h3C in the gnt1 cycle; subsequent port-0 read of address 31 returns 8'h3C.
REQ-026 Contention: req0 and req1 held high continuously from reset -> grant order 0, 1, 0, 1, one access every 2 cycles, never two gnts in the same cycle.
REQ-027 Early drop: req0 drops in the cycle after the winner is registered -> access still completes with gnt0 and done0; rdata1 unchanged throughout.
REQ-028 Boundaries: back-to-back reads of addresses 0 and 31 on alternating ports -> correct data per port; mem_rd and mem_wr never high together.
